unified_mem_arbiter: RTL

- Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each access as a request/ack transaction and generates the stall signals for the PC and pipeline registers.
- Data accesses have priority; a starvation limit guarantees forward progress for fetch.
- A timeout watchdog flags a memory that never acknowledges.

---
 rtl/unified_mem_arbiter_pkg.sv | 18 +
 rtl/arb_timeout_counter.sv | 30 +++
 rtl/unified_mem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified I/D memory arbiter.
// Size codes match the data-memory encoding so store sizes pass straight through.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_ACK_TIMEOUT  = 16;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counter with synchronous clear, enable and saturation at LIMIT; tc is high while the count equals LIMIT.
// Latency: tc reflects the registered count. No backpressure; clear wins over enable.
module arb_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LIM);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store; data wins unless fetch has starved.
// Latency: request to Ready is 2 cycles with a zero-wait memory; requesters stall via StallIF/StallMEM until Ready.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRdata,
  output logic              IReady,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  input  logic [1:0]        DSize,
  output logic [DATA_W-1:0] DRdata,
  output logic              DReady,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  output logic [1:0]        MemSize,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck,
  output logic              StallIF,
  output logic              StallMEM,
  output logic              BusErr
);

  arb_state_e state;

  logic idle;
  logic busy;
  logic grant_d;
  logic grant_i;
  logic starve_tc;
  logic tmo_tc;
  logic done;
  logic timed_out;
  logic [DATA_W-1:0] rdata_eff;

  assign idle      = (state == ARB_IDLE);
  assign busy      = !idle;
  assign grant_d   = idle && DReq && (!IReq || !starve_tc);
  assign grant_i   = idle && !grant_d && IReq;
  assign done      = busy && (MemAck || tmo_tc);
  // An ack landing on the terminal watchdog cycle still counts as a clean completion.
  assign timed_out = busy && tmo_tc && !MemAck;
  assign rdata_eff = MemAck ? MemRdata : '0;

  arb_timeout_counter #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (idle && (grant_i || !IReq)),
    .en    (grant_d && IReq),
    .tc    (starve_tc)
  );

  arb_timeout_counter #(.LIMIT(ACK_TIMEOUT - 1)) u_tmo_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (grant_d || grant_i),
    .en    (busy),
    .tc    (tmo_tc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ARB_IDLE;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      MemSize  <= SIZE_WORD;
      IRdata   <= '0;
      DRdata   <= '0;
      IReady   <= 1'b0;
      DReady   <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      if (grant_d) begin
        state    <= ARB_D_BUSY;
        MemReq   <= 1'b1;
        MemWe    <= DWrite;
        MemAddr  <= DAddr;
        MemWdata <= DWdata;
        MemSize  <= DSize;
      end else if (grant_i) begin
        state    <= ARB_I_BUSY;
        MemReq   <= 1'b1;
        MemWe    <= 1'b0;
        MemAddr  <= IAddr;
        MemWdata <= '0;
        MemSize  <= SIZE_WORD;
      end else if (done) begin
        state  <= ARB_IDLE;
        MemReq <= 1'b0;
        if (state == ARB_I_BUSY) begin
          IReady <= 1'b1;
          IRdata <= rdata_eff;
        end else begin
          DReady <= 1'b1;
          if (!MemWe) begin
            DRdata <= rdata_eff;
          end
        end
        if (timed_out) begin
          BusErr <= 1'b1;
        end
      end
    end
  end

  assign StallIF  = IReq && !IReady;
  assign StallMEM = DReq && !DReady;

endmodule
